flags_controller: RTL and testbench

Sequencer that owns the NZCV flags register of the processor datapath. It accepts one conditional instruction at a time and evaluates its 4-bit condition code against the current flags. It then starts or skips execution and, when the instruction sets flags, drives the flags register's update enable and NZCV inputs. It enforces a settle window after every flag update, so the next instruction never evaluates stale flags through the two-cycle flags-register latency.

---
 rtl/flags_controller_if.sv | 25 ++
 rtl/flags_controller.sv | 126 ++++++++++++
 tb/tb_flags_controller.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flags_controller_if.sv
// Instruction/ALU/flags-register handshake bundle for flags_controller.
// master = the datapath side that offers instructions, slave = the controller.
interface flags_controller_if;
    logic       instr_valid;
    logic [3:0] instr_cond;
    logic       instr_set_flags;
    logic       instr_ready;
    logic [3:0] flags;
    logic       alu_done;
    logic [3:0] alu_NZCV;
    logic       exec_start;
    logic       skip;
    logic       CNTRL_update_en;
    logic [3:0] NZCV;

    modport master (
        output instr_valid, instr_cond, instr_set_flags, flags, alu_done, alu_NZCV,
        input  instr_ready, exec_start, skip, CNTRL_update_en, NZCV
    );

    modport slave (
        input  instr_valid, instr_cond, instr_set_flags, flags, alu_done, alu_NZCV,
        output instr_ready, exec_start, skip, CNTRL_update_en, NZCV
    );
endinterface

// File: rtl/flags_controller.sv
// NZCV flags sequencer: evaluates one conditional instruction at a time, drives
// the flags-register update and holds off the next instruction while flags settle.
module flags_controller #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic          CLOCK_50,
    input  logic          RESET,
    flags_controller_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_EXEC,
        ST_SETTLE
    } state_t;

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

    state_t     r_state;
    logic [3:0] r_cond;
    logic       r_set_flags;
    logic       r_exec_start;
    logic       r_skip;
    logic       r_update_en;
    logic [3:0] r_nzcv;
    logic [3:0] r_counter;

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_pass;

    assign w_n = bus.flags[3];
    assign w_z = bus.flags[2];
    assign w_c = bus.flags[1];
    assign w_v = bus.flags[0];

    // Condition decode against the live flags-register output.
    always_comb begin
        w_pass = 1'b0;
        case (r_cond)
            4'd0:  w_pass = w_z;
            4'd1:  w_pass = !w_z;
            4'd2:  w_pass = w_c;
            4'd3:  w_pass = !w_c;
            4'd4:  w_pass = w_n;
            4'd5:  w_pass = !w_n;
            4'd6:  w_pass = w_v;
            4'd7:  w_pass = !w_v;
            4'd8:  w_pass = w_c && !w_z;
            4'd9:  w_pass = !w_c || w_z;
            4'd10: w_pass = (w_n == w_v);
            4'd11: w_pass = (w_n != w_v);
            4'd12: w_pass = !w_z && (w_n == w_v);
            4'd13: w_pass = w_z || (w_n != w_v);
            4'd14: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_cond       <= 4'd0;
            r_set_flags  <= 1'b0;
            r_exec_start <= 1'b0;
            r_skip       <= 1'b0;
            r_update_en  <= 1'b0;
            r_nzcv       <= 4'd0;
            r_counter    <= 4'd0;
        end else begin
            r_exec_start <= 1'b0;
            r_skip       <= 1'b0;
            r_update_en  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        r_cond      <= bus.instr_cond;
                        r_set_flags <= bus.instr_set_flags;
                        r_state     <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (w_pass) begin
                        r_exec_start <= 1'b1;
                        r_state      <= ST_EXEC;
                    end else begin
                        r_skip  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (bus.alu_done) begin
                        if (r_set_flags) begin
                            r_update_en <= 1'b1;
                            r_nzcv      <= bus.alu_NZCV;
                            r_counter   <= LP_SETTLE;
                            r_state     <= ST_SETTLE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    // Counter bottoms out at zero; it is never reloaded here.
                    if (r_counter <= 4'd1) begin
                        r_counter <= 4'd0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_counter <= r_counter - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.instr_ready     = (r_state == ST_IDLE);
    assign bus.exec_start      = r_exec_start;
    assign bus.skip            = r_skip;
    assign bus.CNTRL_update_en = r_update_en;
    assign bus.NZCV            = r_nzcv;

endmodule

// File: tb/tb_flags_controller.sv
// Scoreboard bench for flags_controller: stimulus queues expected pulses, a
// negedge monitor pops and compares them; a second instance covers SETTLE_CYCLES=4.
module tb_flags_controller;

    localparam int K_EXEC = 0;
    localparam int K_SKIP = 1;
    localparam int K_UPD  = 2;

    typedef struct {
        int         kind;
        logic [3:0] nzcv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst4 = 1'b1;
    always #5 clk = ~clk;

    flags_controller_if ifc ();
    flags_controller_if ifc4 ();

    flags_controller #(.SETTLE_CYCLES(2)) dut  (.CLOCK_50(clk), .RESET(rst),  .bus(ifc));
    flags_controller #(.SETTLE_CYCLES(4)) dut4 (.CLOCK_50(clk), .RESET(rst4), .bus(ifc4));

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    // Two-cycle-latency flags register fed by the controller, with a bench load port.
    logic       flags_load_en  = 1'b0;
    logic [3:0] flags_load_val = 4'd0;
    logic       fr_pend_v      = 1'b0;
    logic [3:0] fr_pend        = 4'd0;
    always @(posedge clk) begin
        fr_pend_v <= ifc.CNTRL_update_en;
        fr_pend   <= ifc.NZCV;
        if (flags_load_en)  ifc.flags <= flags_load_val;
        else if (fr_pend_v) ifc.flags <= fr_pend;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int kind, input logic [3:0] nzcv);
        exp_t e;
        e.kind = kind;
        e.nzcv = nzcv;
        exp_q.push_back(e);
    endtask

    task automatic load_flags(input logic [3:0] v);
        flags_load_val = v;
        flags_load_en  = 1'b1;
        @(posedge clk);
        #1 flags_load_en = 1'b0;
    endtask

    task automatic offer(input logic [3:0] c, input logic sf);
        int n;
        n = 0;
        @(negedge clk);
        while (!ifc.instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("offer_ready", 32'(ifc.instr_ready), 32'd1);
        ifc.instr_valid     = 1'b1;
        ifc.instr_cond      = c;
        ifc.instr_set_flags = sf;
        @(posedge clk);
        #1 ifc.instr_valid = 1'b0;
        $display("offer cond=%0d set_flags=%0b accepted at %0t", c, sf, $time);
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    int         mon_np;
    int         mon_kind;
    exp_t       mon_e;
    always @(negedge clk) begin
        mon_np = int'(ifc.exec_start) + int'(ifc.skip) + int'(ifc.CNTRL_update_en);
        if (mon_np != 0) begin
            checks++;
            mon_kind = ifc.exec_start ? K_EXEC : (ifc.skip ? K_SKIP : K_UPD);
            if (mon_np > 1) begin
                failures++;
                $display("FAIL pulse_onehot actual=%0d pulses required=1", mon_np);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse actual kind=%0d required=none", mon_kind);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind != mon_kind || (mon_kind == K_UPD && mon_e.nzcv !== ifc.NZCV)) begin
                    failures++;
                    $display("FAIL scoreboard actual kind=%0d nzcv=%b required kind=%0d nzcv=%b",
                             mon_kind, ifc.NZCV, mon_e.kind, mon_e.nzcv);
                end else begin
                    $display("pulse kind=%0d nzcv=%b ok at %0t", mon_kind, ifc.NZCV, $time);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [3:0]  sweep_flags [2];
    logic [15:0] sweep_mask  [2];
    logic        pass_bit;
    int          n;

    initial begin
        // Pass masks hand-derived: 0100 -> EQ CC PL VC LS GE LE AL; 1010 -> NE CS MI VC HI LT LE AL
        sweep_flags[0] = 4'b0100; sweep_mask[0] = 16'h66A9;
        sweep_flags[1] = 4'b1010; sweep_mask[1] = 16'h6996;

        ifc.instr_valid = 0; ifc.instr_cond = 0; ifc.instr_set_flags = 0;
        ifc.alu_done = 0; ifc.alu_NZCV = 0;
        ifc4.instr_valid = 0; ifc4.instr_cond = 0; ifc4.instr_set_flags = 0;
        ifc4.alu_done = 0; ifc4.alu_NZCV = 0; ifc4.flags = 4'd0;

        // Reset asserted mid-cycle takes effect immediately.
        #2 rst = 1'b1;
        #1;
        chk("rst_ready",  32'(ifc.instr_ready),     32'd1);
        chk("rst_exec",   32'(ifc.exec_start),      32'd0);
        chk("rst_skip",   32'(ifc.skip),            32'd0);
        chk("rst_upd",    32'(ifc.CNTRL_update_en), 32'd0);
        chk("rst_nzcv",   32'(ifc.NZCV),            32'd0);
        load_flags(4'b0100);
        @(negedge clk) rst = 1'b0;

        // Idle with a spurious alu_done: no pulse, ready stays high.
        ifc.alu_done = 1'b1; ifc.alu_NZCV = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(ifc.instr_ready), 32'd1);
        end
        ifc.alu_done = 1'b0;
        chk("idle_nzcv", 32'(ifc.NZCV), 32'd0);

        // Condition sweep on two flag patterns, reset after each instruction.
        for (int s = 0; s < 2; s++) begin
            load_flags(sweep_flags[s]);
            for (int c = 0; c < 16; c++) begin
                pass_bit = sweep_mask[s][c];
                push_exp(pass_bit ? K_EXEC : K_SKIP, 4'd0);
                offer(4'(c), 1'b0);
                @(posedge clk);
                @(negedge clk);
                chk("sweep_ready_after_eval", 32'(ifc.instr_ready), pass_bit ? 32'd0 : 32'd1);
                #1 rst = 1'b1;
                #1;
                chk("sweep_rst_ready", 32'(ifc.instr_ready), 32'd1);
                chk("sweep_rst_nzcv",  32'(ifc.NZCV),        32'd0);
                @(negedge clk) rst = 1'b0;
            end
        end

        // Flag-setting instruction, alu_done three cycles after exec_start.
        load_flags(4'b0000);
        push_exp(K_EXEC, 4'd0);
        push_exp(K_UPD, 4'b1001);
        offer(4'd14, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 ifc.alu_done = 1'b1; ifc.alu_NZCV = 4'b1001;
        @(posedge clk);
        #1 ifc.alu_NZCV = 4'b0110; // alu_done held into SETTLE must be ignored
        @(negedge clk);
        chk("upd_ready_m",  32'(ifc.instr_ready),     32'd0);
        chk("upd_pulse_m",  32'(ifc.CNTRL_update_en), 32'd1);
        chk("upd_nzcv_m",   32'(ifc.NZCV),            32'b1001);
        @(negedge clk);
        chk("upd_ready_m1", 32'(ifc.instr_ready),     32'd0);
        chk("upd_pulse_m1", 32'(ifc.CNTRL_update_en), 32'd0);
        @(negedge clk);
        chk("upd_ready_m2", 32'(ifc.instr_ready),     32'd1);
        chk("upd_nzcv_m2",  32'(ifc.NZCV),            32'b1001);
        ifc.alu_done = 1'b0;

        // Dependent pair: second (EQ) is held off until flags carry Z=1.
        push_exp(K_EXEC, 4'd0);
        push_exp(K_UPD, 4'b0100);
        push_exp(K_EXEC, 4'd0);
        offer(4'd14, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 ifc.alu_done = 1'b1; ifc.alu_NZCV = 4'b0100;
        ifc.instr_valid = 1'b1; ifc.instr_cond = 4'd0; ifc.instr_set_flags = 1'b0;
        @(posedge clk);
        #1 ifc.alu_done = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ifc.instr_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("dep_holdoff_cycles", 32'(n), 32'd2);
        @(posedge clk);
        #1 ifc.instr_valid = 1'b0;
        chk("dep_accepted", 32'(ifc.instr_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("dep_in_exec", 32'(ifc.instr_ready), 32'd0);

        // Non-flag instruction completes: IDLE next cycle, NZCV held, no update.
        ifc.alu_done = 1'b1; ifc.alu_NZCV = 4'b1111;
        @(posedge clk);
        #1 ifc.alu_done = 1'b0;
        @(negedge clk);
        chk("noflag_ready", 32'(ifc.instr_ready),     32'd1);
        chk("noflag_nzcv",  32'(ifc.NZCV),            32'b0100);
        chk("noflag_upd",   32'(ifc.CNTRL_update_en), 32'd0);

        // alu_done present on the edge that enters EXEC is not seen.
        push_exp(K_EXEC, 4'd0);
        push_exp(K_UPD, 4'b0110);
        offer(4'd14, 1'b1);
        ifc.alu_done = 1'b1; ifc.alu_NZCV = 4'b0011;
        @(posedge clk);
        #1 ifc.alu_done = 1'b0;
        @(negedge clk);
        chk("early_done_ready", 32'(ifc.instr_ready), 32'd0);
        @(negedge clk);
        chk("early_done_nzcv",  32'(ifc.NZCV), 32'b0100);
        ifc.alu_done = 1'b1; ifc.alu_NZCV = 4'b0110;
        @(posedge clk);
        #1 ifc.alu_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_done_nzcv", 32'(ifc.NZCV), 32'b0110);

        // SETTLE_CYCLES=4 instance: reset one cycle into SETTLE.
        @(negedge clk) rst4 = 1'b0;
        ifc4.instr_valid = 1'b1; ifc4.instr_cond = 4'd14; ifc4.instr_set_flags = 1'b1;
        @(posedge clk);
        #1 ifc4.instr_valid = 1'b0;
        @(posedge clk);
        #1 chk("s4_exec", 32'(ifc4.exec_start), 32'd1);
        ifc4.alu_done = 1'b1; ifc4.alu_NZCV = 4'b1100;
        @(posedge clk);
        #1 ifc4.alu_done = 1'b0;
        chk("s4_upd",  32'(ifc4.CNTRL_update_en), 32'd1);
        chk("s4_nzcv", 32'(ifc4.NZCV),            32'b1100);
        @(posedge clk);
        #1 chk("s4_settle_ready", 32'(ifc4.instr_ready), 32'd0);
        rst4 = 1'b1;
        #1;
        chk("s4_rst_ready", 32'(ifc4.instr_ready),     32'd1);
        chk("s4_rst_nzcv",  32'(ifc4.NZCV),            32'd0);
        chk("s4_rst_upd",   32'(ifc4.CNTRL_update_en), 32'd0);
        @(negedge clk) rst4 = 1'b0;
        ifc4.instr_valid = 1'b1; ifc4.instr_cond = 4'd15; ifc4.instr_set_flags = 1'b0;
        @(posedge clk);
        #1 ifc4.instr_valid = 1'b0;
        chk("s4_accept_first_edge", 32'(ifc4.instr_ready), 32'd0);
        @(posedge clk);
        #1 chk("s4_skip", 32'(ifc4.skip), 32'd1);
        $display("dut4 reset-in-settle sequence done at %0t", $time);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
